aes_round_ctrl: RTL and testbench

- Iterative round sequencer for the AES-128 core, running in the `clk` (HSOSC) domain.
- Synchronizes the MCU-driven `load` strobe and detects its falling edge, which marks the end of the SPI key/plaintext shift.
- Steps the core datapath through the initial AddRoundKey and rounds 1..NR, supplying the round number, control enables and the key-schedule Rcon byte.
- Raises `done` for the SPI block to capture the result.

---
 rtl/aes_ctrl_pkg.sv | 22 ++
 rtl/sync_edge.sv | 41 ++++
 rtl/aes_round_ctrl.sv | 157 +++++++++++++++
 tb/tb_aes_round_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES-128 round sequencer.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package aes_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOADING,
    INIT,
    ROUND,
    DONE
  } aes_ctrl_state_t;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1B;

  // Multiply by x in GF(2^8), reducing modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous strobe, with rise/fall pulses.
// Latency: STAGES cycles pin-to-level; edges are one cycle wide after that.
// Backpressure: none; the input is sampled every clk cycle.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;
  logic              prev_q;
  logic              prev_d;

  // Shift the pin into the chain; remember the last synchronized level.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    prev_d = sync_q[STAGES-1];
  end

  // Synchronizer chain and edge-detect history register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign dout = sync_q[STAGES-1];
  assign rise = ~prev_q & dout;
  assign fall = prev_q & ~dout;

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 round sequencer: INIT AddRoundKey, rounds 1..NR, then done.
// Latency: NR+2 clk cycles from the synchronized load falling edge to done.
// Backpressure: optional stall input (macro AES_ROUND_CTRL_STALL_EN) freezes the sequence.
module aes_round_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int NR          = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
`ifdef AES_ROUND_CTRL_STALL_EN
  input  logic       stall,
`endif
  output logic [3:0] round_num,
  output logic       sel_initial,
  output logic       state_en,
  output logic       key_en,
  output logic       last_round,
  output logic [7:0] rcon,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] NR_L = 4'(NR);

  logic load_s;
  logic load_rise;
  logic load_fall;
  logic stall_in;

`ifdef AES_ROUND_CTRL_STALL_EN
  assign stall_in = stall;
`else
  assign stall_in = 1'b0;
`endif

  sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_load_sync (
    .clk   (clk),
    .reset (reset),
    .din   (load),
    .dout  (load_s),
    .rise  (load_rise),
    .fall  (load_fall)
  );

  aes_ctrl_state_t state_q, state_d;
  logic [3:0]      round_q, round_d;
  logic [7:0]      rcon_q, rcon_d;
  logic            hold;
  logic            sel_initial_q, sel_initial_d;
  logic            en_q, en_d;
  logic            last_round_q, last_round_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // Next state, round counter and Rcon. While INIT/ROUND are active load_s was
  // low the cycle before, so a high load_s there is always a rising edge.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    rcon_d  = rcon_q;
    hold    = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_s) state_d = LOADING;
      end
      LOADING: begin
        if (load_fall) state_d = INIT;
      end
      INIT: begin
        if (load_rise) begin
          state_d = LOADING;
          round_d = '0;
          rcon_d  = '0;
        end else if (stall_in) begin
          hold = 1'b1;
        end else begin
          state_d = ROUND;
          round_d = 4'd1;
          rcon_d  = RCON_INIT;
        end
      end
      ROUND: begin
        if (load_rise) begin
          state_d = LOADING;
          round_d = '0;
          rcon_d  = '0;
        end else if (stall_in) begin
          hold = 1'b1;
        end else if (round_q == NR_L) begin
          state_d = DONE;
          rcon_d  = '0;
        end else begin
          round_d = round_q + 4'd1;
          rcon_d  = xtime(rcon_q);
        end
      end
      DONE: begin
        if (load_s) begin
          state_d = LOADING;
          round_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        round_d = '0;
        rcon_d  = '0;
      end
    endcase
  end

  // Moore outputs decoded from the next state so they register alongside it.
  always_comb begin
    sel_initial_d = (state_d == INIT);
    busy_d        = (state_d == INIT) || (state_d == ROUND);
    en_d          = busy_d && !hold;
    last_round_d  = (state_d == ROUND) && (round_d == NR_L);
    done_d        = (state_d == DONE);
  end

  // State, counter and output registers; reset aborts from any state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      round_q       <= '0;
      rcon_q        <= '0;
      sel_initial_q <= 1'b0;
      en_q          <= 1'b0;
      last_round_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      round_q       <= round_d;
      rcon_q        <= rcon_d;
      sel_initial_q <= sel_initial_d;
      en_q          <= en_d;
      last_round_q  <= last_round_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign round_num   = round_q;
  assign rcon        = rcon_q;
  assign sel_initial = sel_initial_q;
  assign state_en    = en_q;
  assign key_en      = en_q;
  assign last_round  = last_round_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for the AES round sequencer with hand-derived expectations.
// Latency: checks exact cycle positions relative to the synchronized load fall.
// Backpressure: stall scenario only when AES_ROUND_CTRL_STALL_EN is defined.
module tb_aes_round_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
`ifdef AES_ROUND_CTRL_STALL_EN
  logic       stall;
`endif
  logic [3:0] round_num;
  logic       sel_initial;
  logic       state_en;
  logic       key_en;
  logic       last_round;
  logic [7:0] rcon;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] rcon_tab [1:10];

  always #5 clk = ~clk;

  aes_round_ctrl #(
    .NR          (10),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
`ifdef AES_ROUND_CTRL_STALL_EN
    .stall       (stall),
`endif
    .round_num   (round_num),
    .sel_initial (sel_initial),
    .state_en    (state_en),
    .key_en      (key_en),
    .last_round  (last_round),
    .rcon        (rcon),
    .busy        (busy),
    .done        (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // {round_num, sel_initial, state_en, key_en, last_round, busy, done, rcon}
  function automatic logic [17:0] outs();
    return {round_num, sel_initial, state_en, key_en, last_round, busy, done, rcon};
  endfunction

  function automatic logic [17:0] ev(input int rn, input bit sel, input bit en,
                                     input bit last, input bit bsy, input bit dn,
                                     input logic [7:0] rc);
    return {4'(rn), sel, en, en, last, bsy, dn, rc};
  endfunction

  // Full encryption: load high 20 cycles, drop, then walk T..T+12.
  task automatic run_enc(input string tag);
    logic [17:0] e;
    load = 1'b1;
    tick(20);
    load = 1'b0;
    tick(2);
    check_eq({tag, "_T_loading"}, 32'(outs()), 32'(ev(0, 0, 0, 0, 0, 0, 8'h00)));
    tick(1);
    e = ev(0, 1, 1, 0, 1, 0, 8'h00);
    check_eq({tag, "_init"}, 32'(outs() >> 8), 32'(e >> 8));
    for (int r = 1; r <= 10; r++) begin
      tick(1);
      check_eq($sformatf("%s_round%0d", tag, r), 32'(outs()),
               32'(ev(r, 0, 1, (r == 10), 1, 0, rcon_tab[r])));
    end
    tick(1);
    e = ev(10, 0, 0, 0, 0, 1, 8'h00);
    check_eq({tag, "_done"}, 32'(outs() >> 8), 32'(e >> 8));
  endtask

  initial begin
    rcon_tab[1] = 8'h01; rcon_tab[2] = 8'h02; rcon_tab[3]  = 8'h04;
    rcon_tab[4] = 8'h08; rcon_tab[5] = 8'h10; rcon_tab[6]  = 8'h20;
    rcon_tab[7] = 8'h40; rcon_tab[8] = 8'h80; rcon_tab[9]  = 8'h1B;
    rcon_tab[10] = 8'h36;
`ifdef AES_ROUND_CTRL_STALL_EN
    stall = 1'b0;
`endif
    reset = 1'b1;
    load  = 1'b0;

    // Reset held while load toggles: everything stays at zero.
    tick(2);
    load = 1'b1;
    tick(3);
    check_eq("reset_hold", 32'(outs()), 32'(ev(0, 0, 0, 0, 0, 0, 8'h00)));
    load = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(5);
    check_eq("idle_after_reset", 32'(outs()), 32'(ev(0, 0, 0, 0, 0, 0, 8'h00)));

    // Glitch on the pin between rising edges is never sampled.
    load = 1'b1;
    #2;
    load = 1'b0;
    tick(10);
    check_eq("short_pulse_ignored", 32'(outs()), 32'(ev(0, 0, 0, 0, 0, 0, 8'h00)));

    run_enc("enc1");

    // done persists while load stays low, then drops SYNC_STAGES+1 cycles after load rises.
    tick(5);
    check_eq("done_hold", 32'(done), 32'd1);
    load = 1'b1;
    tick(2);
    check_eq("done_before_drop", 32'(done), 32'd1);
    tick(1);
    check_eq("done_dropped", 32'(outs()), 32'(ev(0, 0, 0, 0, 0, 0, 8'h00)));

    run_enc("enc2");

    // Abort: pin rises during round 5, load_s seen two cycles later at round 7.
    load = 1'b1;
    tick(20);
    load = 1'b0;
    tick(3);
    tick(5);
    check_eq("abort_round5", 32'(outs()), 32'(ev(5, 0, 1, 0, 1, 0, 8'h10)));
    load = 1'b1;
    tick(2);
    check_eq("abort_round7", 32'(outs()), 32'(ev(7, 0, 1, 0, 1, 0, 8'h40)));
    tick(1);
    check_eq("abort_cleared", 32'(outs()), 32'(ev(0, 0, 0, 0, 0, 0, 8'h00)));
    tick(15);
    check_eq("abort_no_done", 32'(outs()), 32'(ev(0, 0, 0, 0, 0, 0, 8'h00)));

    run_enc("enc3");

    // Asynchronous reset in round 7 clears outputs without a clock edge.
    load = 1'b1;
    tick(20);
    load = 1'b0;
    tick(3);
    tick(7);
    check_eq("pre_reset_round7", 32'(outs()), 32'(ev(7, 0, 1, 0, 1, 0, 8'h40)));
    #1;
    reset = 1'b1;
    #1;
    check_eq("async_reset", 32'(outs()), 32'(ev(0, 0, 0, 0, 0, 0, 8'h00)));
    tick(1);
    reset = 1'b0;
    tick(3);
    check_eq("idle_after_async_reset", 32'(outs()), 32'(ev(0, 0, 0, 0, 0, 0, 8'h00)));

`ifdef AES_ROUND_CTRL_STALL_EN
    // Stall sampled in three cycles at round 4: round 4 repeats with enables off.
    load = 1'b1;
    tick(20);
    load = 1'b0;
    tick(3);
    tick(4);
    check_eq("stall_round4", 32'(outs()), 32'(ev(4, 0, 1, 0, 1, 0, 8'h08)));
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (i == 2) stall = 1'b0;
      check_eq($sformatf("stall_hold%0d", i), 32'(outs()), 32'(ev(4, 0, 0, 0, 1, 0, 8'h08)));
    end
    tick(1);
    check_eq("stall_resume", 32'(outs()), 32'(ev(5, 0, 1, 0, 1, 0, 8'h10)));
    tick(5);
    check_eq("stall_round10", 32'(outs()), 32'(ev(10, 0, 1, 1, 1, 0, 8'h36)));
    tick(1);
    check_eq("stall_done_T15", 32'(done), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
